// File: rtl/hash_digest_mem_writer.sv
// hash_digest_mem_writer - streams digest words into a single-port RAM with tail truncation and a done pulse.
// IO_WIDTH must be a power of two so the length splits into word count and tail bits by slicing.
module hash_digest_mem_writer #(
  parameter int IO_WIDTH      = 32,
  parameter int MAX_RAM_DEPTH = 128,
  parameter int AW            = $clog2(MAX_RAM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [IO_WIDTH-1:0] i_output_length,
  input  logic [AW-1:0]       i_base_addr,
  input  logic [IO_WIDTH-1:0] i_data_in,
  input  logic                i_data_in_valid,
  output logic                o_data_in_ready,
  output logic                o_wr_en,
  output logic [AW-1:0]       o_addr,
  output logic [IO_WIDTH-1:0] o_data_out,
  output logic                o_busy,
  output logic                o_done
);

  localparam int RW = $clog2(IO_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t              state, state_next;
  logic [IO_WIDTH-1:0] remaining;
  logic [RW-1:0]       tail;
  logic [AW-1:0]       wr_addr;

  logic [IO_WIDTH-1:0] len_words;
  logic [RW-1:0]       len_tail;
  logic [IO_WIDTH-1:0] n_words;
  logic                handshake;
  logic                last_word;
  logic [IO_WIDTH-1:0] tail_mask;
  logic [AW-1:0]       addr_inc;

  assign len_words = i_output_length >> RW;
  assign len_tail  = i_output_length[RW-1:0];
  assign n_words   = len_words + IO_WIDTH'(len_tail != '0);

  assign o_data_in_ready = (state == RUN) && (remaining != '0);
  assign handshake       = i_data_in_valid && o_data_in_ready;
  assign last_word       = (remaining == IO_WIDTH'(1));
  assign o_busy          = (state != IDLE);
  assign o_done          = (state == DONE);

  // Keep the top `tail` bits of the final word; digest bits are MSB-first.
  assign tail_mask = ~({IO_WIDTH{1'b1}} >> tail);

  // Explicit wrap so non-power-of-two RAM depths still address correctly.
  assign addr_inc = (wr_addr == AW'(MAX_RAM_DEPTH - 1)) ? '0 : wr_addr + AW'(1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next = (n_words == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (handshake && last_word) begin
          state_next = FLUSH;
        end
      end
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      tail       <= '0;
      wr_addr    <= '0;
      o_wr_en    <= 1'b0;
      o_addr     <= '0;
      o_data_out <= '0;
    end else begin
      state   <= state_next;
      o_wr_en <= handshake;
      if (state == IDLE && i_start) begin
        remaining <= n_words;
        tail      <= len_tail;
        wr_addr   <= i_base_addr;
      end
      if (handshake) begin
        remaining <= remaining - IO_WIDTH'(1);
        wr_addr   <= addr_inc;
        o_addr    <= wr_addr;
        if (last_word && tail != '0) begin
          o_data_out <= i_data_in & tail_mask;
        end else begin
          o_data_out <= i_data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_hash_digest_mem_writer.sv
// tb_hash_digest_mem_writer - scoreboard bench for hash_digest_mem_writer.
module tb_hash_digest_mem_writer;

  localparam int W  = 32;
  localparam int D  = 128;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [W-1:0]  i_output_length;
  logic [AW-1:0] i_base_addr;
  logic [W-1:0]  i_data_in;
  logic          i_data_in_valid;
  logic          o_data_in_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_addr;
  logic [W-1:0]  o_data_out;
  logic          o_busy;
  logic          o_done;

  hash_digest_mem_writer #(.IO_WIDTH(W), .MAX_RAM_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_output_length(i_output_length),
    .i_base_addr(i_base_addr), .i_data_in(i_data_in), .i_data_in_valid(i_data_in_valid),
    .o_data_in_ready(o_data_in_ready), .o_wr_en(o_wr_en), .o_addr(o_addr),
    .o_data_out(o_data_out), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] trunc_word(input logic [W-1:0] d, input int r);
    logic [W-1:0] m;
    m = d;
    if (r != 0)
      for (int b = 0; b < W - r; b++) m[b] = 1'b0;
    return m;
  endfunction

  logic [AW+W-1:0] sb[$];
  logic [AW+W-1:0] exp_wr;
  int cyc = 0;
  int hs_count, wr_count, busy_cycles, ready_cycles, done_count, done_cyc, start_cyc;
  int job_len, job_base, job_k, job_n;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (o_wr_en) begin
        wr_count++;
        if (sb.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          exp_wr = sb.pop_front();
          check("wr_addr", o_addr, exp_wr[AW+W-1:W]);
          check("wr_data", o_data_out, exp_wr[W-1:0]);
        end
      end
      if (o_busy) busy_cycles++;
      if (o_data_in_ready) ready_cycles++;
      if (o_done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (o_data_in_ready && i_data_in_valid) begin
        sb.push_back({AW'((job_base + job_k) % D),
                      (job_k == job_n - 1) ? trunc_word(i_data_in, job_len % W) : i_data_in});
        job_k++;
        hs_count++;
      end
    end
  end

  // Caller is positioned 1 time unit after a rising edge.
  task automatic run_job(input int len, input int base, input bit ones, input logic [7:0] vpat,
                         input int plen, input bit mid_start, input int exp_lat, input int exp_ready);
    int guard;
    int idx;
    job_len = len; job_base = base; job_k = 0; job_n = (len + W - 1) / W;
    hs_count = 0; wr_count = 0; busy_cycles = 0; ready_cycles = 0;
    done_count = 0; done_cyc = 0;
    start_cyc = cyc + 1;
    i_start = 1'b1; i_output_length = W'(len); i_base_addr = AW'(base);
    @(posedge clk); #1;
    i_start = 1'b0; i_output_length = $urandom; i_base_addr = AW'($urandom);
    guard = 0; idx = 0;
    while (done_count == 0 && guard < 200) begin
      i_start = mid_start && (idx == 1);
      i_data_in_valid = (idx < plen) ? vpat[idx] : 1'b1;
      i_data_in = ones ? '1 : W'($urandom);
      @(posedge clk); #1;
      guard++; idx++;
    end
    i_start = 1'b0;
    i_data_in_valid = 1'b0;
    check("done_timeout", guard < 200, 1);
    check("done_latency", done_cyc - start_cyc, exp_lat);
    check("busy_cycles", busy_cycles, exp_lat);
    check("ready_cycles", ready_cycles, exp_ready);
    check("handshakes", hs_count, job_n);
    check("writes", wr_count, job_n);
    check("sb_empty", sb.size(), 0);
    check("done_width", done_count, 1);
    check("idle_busy", o_busy, 0);
    check("idle_done", o_done, 0);
    check("idle_ready", o_data_in_ready, 0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_output_length = '0; i_base_addr = '0;
    i_data_in = '0; i_data_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", o_data_in_ready, 0);
    check("rst_wr_en", o_wr_en, 0);
    check("rst_addr", o_addr, 0);
    check("rst_data", o_data_out, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(128, 0,   1'b0, 8'hFF, 0, 1'b0, 6, 4);
    run_job(100, 5,   1'b1, 8'hFF, 0, 1'b0, 6, 4);
    run_job(64,  10,  1'b0, 8'b0000_1001, 4, 1'b0, 6, 4);
    run_job(128, 126, 1'b0, 8'hFF, 0, 1'b0, 6, 4);
    run_job(0,   3,   1'b0, 8'hFF, 0, 1'b0, 1, 0);
    run_job(128, 20,  1'b0, 8'hFF, 0, 1'b1, 6, 4);

    job_len = 128; job_base = 50; job_k = 0; job_n = 4;
    i_start = 1'b1; i_output_length = 128; i_base_addr = 50;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_data_in_valid = 1'b1; i_data_in = W'($urandom);
    @(posedge clk); #1;
    i_data_in = W'($urandom);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_data_in_valid = 1'b0;
    check("mid_rst_ready", o_data_in_ready, 0);
    check("mid_rst_wr_en", o_wr_en, 0);
    check("mid_rst_addr", o_addr, 0);
    check("mid_rst_data", o_data_out, 0);
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", o_done, 0);
    run_job(32, 40, 1'b0, 8'hFF, 0, 1'b0, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_digest_mem_writer.md
# hash_digest_mem_writer

Write-side counterpart of the hash memory read interface: accepts the SHAKE256 digest stream over a valid/ready handshake, one IO_WIDTH word per transfer, and writes it word-by-word into a single-port RAM starting at a programmable base address. It sits between the hash core's output port and the digest/seed RAM. It truncates and zero-pads the final word to the requested bit length and signals completion with a one-cycle done pulse.

## Interface
- IO_WIDTH, 32: data word width and length-field width.
- MAX_RAM_DEPTH, 128: RAM depth in words; address width is AW = `CLOG2(MAX_RAM_DEPTH)`.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_output_length  in  IO_WIDTH  digest length in bits; sampled with i_start.
- i_base_addr  in  AW  first RAM word address; sampled with i_start.
- i_data_in  in  IO_WIDTH  digest word from hash core; first digest bit is in the MSB.
- i_data_in_valid  in  1  i_data_in is valid.
- o_data_in_ready  out  1  block accepts a word this cycle.
- o_wr_en  out  1  RAM write strobe.
- o_addr  out  AW  RAM write address.
- o_data_out  out  IO_WIDTH  RAM write data.
- o_busy  out  1  high from the cycle after an accepted i_start up to and including the o_done cycle.
- o_done  out  1  one-cycle completion pulse.

## Operation
- Word count: N = ceil(i_output_length / IO_WIDTH), latched at start. Tail bits: R = i_output_length mod IO_WIDTH.
- State IDLE: o_data_in_ready=0. On i_start=1, latch N, R and i_base_addr.
  - N>0: go to RUN.
  - N=0: go to DONE. No writes occur.
- State RUN: o_data_in_ready=1 while the remaining count is nonzero.
  - A handshake is i_data_in_valid & o_data_in_ready.
  - Each handshake decrements the remaining count, registers the write, and advances the address.
  - The handshake that makes the count zero moves the state to FLUSH.
- State FLUSH: o_data_in_ready=0. The final registered write is on the RAM port. Next state is DONE.
- State DONE: o_done=1 for exactly one cycle, then IDLE.
- Address: word k goes to (base + k) mod MAX_RAM_DEPTH. The address wraps to 0 past MAX_RAM_DEPTH-1.
- Masking: on the last word, if R≠0, keep bits [IO_WIDTH-1 : IO_WIDTH-R] and force the lower IO_WIDTH-R bits to 0. All other words are written unmodified.
- i_start while not in IDLE is ignored. Length and base changes after start have no effect.
- i_data_in_valid while ready=0 is not consumed; the producer holds the word.
- Reset, including mid-transfer, forces IDLE and clears counters.
- Reset values of all outputs: o_data_in_ready=0, o_wr_en=0, o_addr=0, o_data_out=0, o_busy=0, o_done=0.
- o_addr and o_data_out hold their last values when o_wr_en=0. Outside reset, verification must not check them when o_wr_en=0.

## Timing
- Start to ready: i_start sampled at edge E0; o_data_in_ready=1 from the cycle after E0.
- o_data_in_ready is a registered-state decode and has no combinational path from i_data_in_valid.
- Throughput: one word per cycle while valid stays high. N words with continuous valid take N cycles.
- Write latency: a handshake in cycle t produces o_wr_en=1 with that word's o_addr and o_data_out in cycle t+1, registered.
- Completion: last handshake in cycle t gives last o_wr_en in t+1 (FLUSH), o_done in t+2, and o_busy=0 and IDLE in t+3.
- Zero length: start at E0 gives o_done in the cycle after E0, with no o_wr_en.
- Minimum start-to-done for N words with continuous valid: N+2 cycles after the start cycle.
- Back-to-back: a new i_start is accepted in the first IDLE cycle after o_done.

## Test plan
- 128-bit digest, base 0, valid held high:
  - 4 writes at addr 0,1,2,3 on consecutive cycles, data unmodified.
  - o_done 2 cycles after the 4th handshake.
  - o_busy high for exactly 6 cycles.
- Partial word, length 100 bits, base 5, input words all 0xFFFFFFFF:
  - 4 writes at addr 5..8.
  - Last word 0xF0000000 (R=4); the others 0xFFFFFFFF.
- Throttled producer, length 64 bits:
  - valid pattern 1,0,0,1 gives writes only one cycle after each handshake.
  - Ready stays high while 1 word is still remaining; no extra writes.
- Wrap, MAX_RAM_DEPTH=128, base 126, length 128 bits: write addresses 126, 127, 0, 1.
- Zero length plus ignored restart:
  - length 0: o_done the cycle after start, no o_wr_en.
  - i_start pulsed mid-RUN of a 128-bit job has no effect.
- Reset mid-operation:
  - Assert rst after 2 of 4 handshakes: next cycle all outputs are 0 and the state is IDLE.
  - A fresh 32-bit job then writes 1 word and pulses o_done.
